// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad types, dimensions and row/column to hex key map
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        REL_DB
    } kp_state_e;

    // Entry {r, c}: row 0 is the top row "1 2 3 A", row 3 is "0 F E D".
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        return KEY_MAP[{r, c}];
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - dwell counter giving a column-advance and a settled-sample strobe
module scan_tick_gen #(
    parameter int DIV    = 50000,
    parameter int SETTLE = 8
) (
    input  logic clk,
    input  logic rst,
    output logic col_adv,
    output logic sample_en
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == W'(DIV - 1)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign col_adv   = (cnt_q == W'(DIV - 1));
    assign sample_en = (cnt_q == W'(SETTLE));

endmodule

// File: rtl/keypad_scan_debounce.sv
// rtl/keypad_scan_debounce.sv - 4x4 keypad column scan, single-key debounce and hex encode
// Auto-repeat strobes while a key is held are built only with KEYPAD_AUTO_REPEAT_EN.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int SETTLE     = 8,
    parameter int DEBOUNCE_N = 20,
    parameter int REPEAT_N   = 500
) (
    input  logic                clk,
    input  logic                rst,
    output logic [NUM_COLS-1:0] col,
    input  logic [NUM_ROWS-1:0] row,
    output logic [3:0]          key,
    output logic                key_valid,
    output logic                key_held,
    output logic                multi_err
);
    localparam int DBW = (DEBOUNCE_N > 2) ? $clog2(DEBOUNCE_N) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_N - 2);

    if (SCAN_DIV < 4 || SETTLE >= SCAN_DIV || DEBOUNCE_N < 2 || REPEAT_N < 1) begin : g_bad_params
        $error("keypad_scan_debounce: illegal parameter set");
    end

    logic col_adv, sample_en;

    scan_tick_gen #(
        .DIV    (SCAN_DIV),
        .SETTLE (SETTLE)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .col_adv   (col_adv),
        .sample_en (sample_en)
    );

    logic [NUM_ROWS-1:0] row_s1_q, row_s2_q;
    kp_state_e           state_q, state_d;
    logic [DBW-1:0]      db_cnt_q, db_cnt_d;
    logic [1:0]          cand_r_q, cand_r_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0] col_q, col_d;
    logic [3:0]          key_q, key_d;
    logic                key_valid_q, key_valid_d;
    logic                key_held_q, key_held_d;
    logic                multi_err_q, multi_err_d;
`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam int RPW = (REPEAT_N > 1) ? $clog2(REPEAT_N) : 1;
    localparam logic [RPW-1:0] RPT_LAST = RPW'(REPEAT_N - 1);
    logic [RPW-1:0]      rpt_cnt_q, rpt_cnt_d;
`endif

    // A multi-row sample is flagged but otherwise looks exactly like "no key".
    logic       hit, multi;
    logic [1:0] hit_r;
    always_comb begin
        hit   = 1'b0;
        multi = 1'b0;
        hit_r = 2'd0;
        case (row_s2_q)
            4'b1111: ;
            4'b1110: begin hit = 1'b1; hit_r = 2'd0; end
            4'b1101: begin hit = 1'b1; hit_r = 2'd1; end
            4'b1011: begin hit = 1'b1; hit_r = 2'd2; end
            4'b0111: begin hit = 1'b1; hit_r = 2'd3; end
            default: multi = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        cand_r_d    = cand_r_q;
        col_idx_d   = col_idx_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        multi_err_d = multi_err_q;
`ifdef KEYPAD_AUTO_REPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
`endif
        if (sample_en) begin
            if (multi) begin
                multi_err_d = 1'b1;
            end
            unique case (state_q)
                SCAN: begin
                    if (hit) begin
                        cand_r_d = hit_r;
                        db_cnt_d = '0;
                        state_d  = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (hit && hit_r == cand_r_q) begin
                        if (db_cnt_q == DB_LAST) begin
                            key_d       = key_code(cand_r_q, col_idx_q);
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            multi_err_d = 1'b0;
                            db_cnt_d    = '0;
                            state_d     = HELD;
`ifdef KEYPAD_AUTO_REPEAT_EN
                            rpt_cnt_d   = '0;
`endif
                        end else begin
                            db_cnt_d = db_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (!hit) begin
                        db_cnt_d = '0;
                        state_d  = REL_DB;
                    end
`ifdef KEYPAD_AUTO_REPEAT_EN
                    else if (rpt_cnt_q == RPT_LAST) begin
                        key_valid_d = 1'b1;
                        rpt_cnt_d   = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
`endif
                end
                REL_DB: begin
                    if (hit) begin
                        state_d = HELD;
`ifdef KEYPAD_AUTO_REPEAT_EN
                        rpt_cnt_d = '0;
`endif
                    end else if (db_cnt_q == DB_LAST) begin
                        key_held_d = 1'b0;
                        state_d    = SCAN;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
        // Rotation is frozen on the candidate column for as long as a key is being tracked.
        if (col_adv && state_d == SCAN) begin
            col_idx_d = col_idx_q + 1'b1;
        end
        col_d = ~(4'b1000 >> col_idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q    <= '1;
            row_s2_q    <= '1;
            state_q     <= SCAN;
            db_cnt_q    <= '0;
            cand_r_q    <= '0;
            col_idx_q   <= '0;
            col_q       <= 4'b0111;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            multi_err_q <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
            rpt_cnt_q   <= '0;
`endif
        end else begin
            row_s1_q    <= row;
            row_s2_q    <= row_s1_q;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            cand_r_q    <= cand_r_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            multi_err_q <= multi_err_d;
`ifdef KEYPAD_AUTO_REPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
`endif
        end
    end

    assign col       = col_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign multi_err = multi_err_q;

endmodule
